// File: rtl/mesi_isc_breq_arb.sv
// Broadcast request front end: per-port capture FIFOs feeding a round-robin output register.
// Optional build macro MESI_BREQ_STAT_EN adds handshake/stall statistics ports.
module mesi_isc_breq_arb #(
  parameter int MBUS_CMD_WIDTH      = 3,
  parameter int ADDR_WIDTH          = 32,
  parameter int BROAD_TYPE_WIDTH    = 2,
  parameter int BROAD_ID_WIDTH      = 5,
  parameter int BREQ_FIFO_SIZE      = 2,
  parameter int BREQ_FIFO_SIZE_LOG2 = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [MBUS_CMD_WIDTH-1:0]   mbus_cmd3_i,
  input  logic [MBUS_CMD_WIDTH-1:0]   mbus_cmd2_i,
  input  logic [MBUS_CMD_WIDTH-1:0]   mbus_cmd1_i,
  input  logic [MBUS_CMD_WIDTH-1:0]   mbus_cmd0_i,
  input  logic [ADDR_WIDTH-1:0]       mbus_addr3_i,
  input  logic [ADDR_WIDTH-1:0]       mbus_addr2_i,
  input  logic [ADDR_WIDTH-1:0]       mbus_addr1_i,
  input  logic [ADDR_WIDTH-1:0]       mbus_addr0_i,
  output logic                        mbus_ack3_o,
  output logic                        mbus_ack2_o,
  output logic                        mbus_ack1_o,
  output logic                        mbus_ack0_o,
  output logic                        broad_valid_o,
  input  logic                        broad_ready_i,
  output logic [ADDR_WIDTH-1:0]       broad_addr_o,
  output logic [BROAD_TYPE_WIDTH-1:0] broad_type_o,
  output logic [1:0]                  broad_cpu_id_o,
  output logic [BROAD_ID_WIDTH-1:0]   broad_id_o
`ifdef MESI_BREQ_STAT_EN
  ,
  output logic [15:0]                 breq_stat_o,
  output logic [3:0]                  breq_stall_o
`endif
);

  localparam int NP = 4;
  localparam int SW = BROAD_ID_WIDTH - 2;
  localparam int PW = BREQ_FIFO_SIZE_LOG2;
  localparam int CW = BREQ_FIFO_SIZE_LOG2 + 1;

  localparam logic [PW-1:0] PTR_LAST =
    PW'(BREQ_FIFO_SIZE - 1);
  localparam logic [CW-1:0] CNT_FULL =
    CW'(BREQ_FIFO_SIZE);
  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WRB =
    MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RDB =
    MBUS_CMD_WIDTH'(4);
  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_WR =
    BROAD_TYPE_WIDTH'(1);
  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_RD =
    BROAD_TYPE_WIDTH'(2);

  logic [MBUS_CMD_WIDTH-1:0] cmd  [NP];
  logic [ADDR_WIDTH-1:0]     addr [NP];

  assign cmd[0]  = mbus_cmd0_i;
  assign cmd[1]  = mbus_cmd1_i;
  assign cmd[2]  = mbus_cmd2_i;
  assign cmd[3]  = mbus_cmd3_i;
  assign addr[0] = mbus_addr0_i;
  assign addr[1] = mbus_addr1_i;
  assign addr[2] = mbus_addr2_i;
  assign addr[3] = mbus_addr3_i;

  logic [NP-1:0] bcast;
  logic [NP-1:0] full;
  logic [NP-1:0] nempty;
  logic [NP-1:0] cap;
  logic [NP-1:0] pop;
  logic [NP-1:0] ack_q, ack_d;

  logic [CW-1:0] cnt_q [NP];
  logic [CW-1:0] cnt_d [NP];
  logic [PW-1:0] wp_q  [NP];
  logic [PW-1:0] wp_d  [NP];
  logic [PW-1:0] rp_q  [NP];
  logic [PW-1:0] rp_d  [NP];
  logic [SW-1:0] seq_q [NP];
  logic [SW-1:0] seq_d [NP];

  logic [ADDR_WIDTH-1:0]       f_addr_q [NP][BREQ_FIFO_SIZE];
  logic [BROAD_TYPE_WIDTH-1:0] f_type_q [NP][BREQ_FIFO_SIZE];
  logic [SW-1:0]               f_seq_q  [NP][BREQ_FIFO_SIZE];

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt;
  logic       gnt_vld;
  logic       load;

  logic                        valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]       oaddr_q, oaddr_d;
  logic [BROAD_TYPE_WIDTH-1:0] otype_q, otype_d;
  logic [1:0]                  ocpu_q, ocpu_d;
  logic [BROAD_ID_WIDTH-1:0]   oid_q, oid_d;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] v
  );
    return (v == PTR_LAST) ? '0 : v + PW'(1);
  endfunction

  // Ack high means the CPU is still holding the command just taken.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      bcast[p]  = (cmd[p] == CMD_WRB) ||
                  (cmd[p] == CMD_RDB);
      full[p]   = (cnt_q[p] == CNT_FULL);
      nempty[p] = (cnt_q[p] != '0);
      cap[p]    = bcast[p] && !full[p] && !ack_q[p];
    end
  end

  assign ack_d = cap;

  always_comb begin
    logic [1:0] idx;
    gnt_vld = 1'b0;
    gnt     = ptr_q;
    idx     = ptr_q;
    for (int k = 1; k <= NP; k++) begin
      idx = ptr_q + 2'(k);
      if (!gnt_vld && nempty[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  assign load = !valid_q || broad_ready_i;

  always_comb begin
    for (int p = 0; p < NP; p++)
      pop[p] = load && gnt_vld && (gnt == 2'(p));
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      wp_d[p]  = wp_q[p];
      rp_d[p]  = rp_q[p];
      seq_d[p] = seq_q[p];
      cnt_d[p] = cnt_q[p];
      if (cap[p]) begin
        wp_d[p]  = nxt(wp_q[p]);
        seq_d[p] = seq_q[p] + SW'(1);
      end
      if (pop[p])
        rp_d[p] = nxt(rp_q[p]);
      case ({cap[p], pop[p]})
        2'b10:   cnt_d[p] = cnt_q[p] + CW'(1);
        2'b01:   cnt_d[p] = cnt_q[p] - CW'(1);
        default: cnt_d[p] = cnt_q[p];
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    oaddr_d = oaddr_q;
    otype_d = otype_q;
    ocpu_d  = ocpu_q;
    oid_d   = oid_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = gnt_vld;
      if (gnt_vld) begin
        oaddr_d = f_addr_q[gnt][rp_q[gnt]];
        otype_d = f_type_q[gnt][rp_q[gnt]];
        ocpu_d  = gnt;
        oid_d   = {gnt, f_seq_q[gnt][rp_q[gnt]]};
        ptr_d   = gnt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= '0;
      valid_q <= 1'b0;
      oaddr_q <= '0;
      otype_q <= '0;
      ocpu_q  <= '0;
      oid_q   <= '0;
      ptr_q   <= 2'd3;
      for (int p = 0; p < NP; p++) begin
        cnt_q[p] <= '0;
        wp_q[p]  <= '0;
        rp_q[p]  <= '0;
        seq_q[p] <= '0;
      end
    end else begin
      ack_q   <= ack_d;
      valid_q <= valid_d;
      oaddr_q <= oaddr_d;
      otype_q <= otype_d;
      ocpu_q  <= ocpu_d;
      oid_q   <= oid_d;
      ptr_q   <= ptr_d;
      for (int p = 0; p < NP; p++) begin
        cnt_q[p] <= cnt_d[p];
        wp_q[p]  <= wp_d[p];
        rp_q[p]  <= rp_d[p];
        seq_q[p] <= seq_d[p];
      end
    end
  end

  // Entry storage needs no reset: only counted slots are ever read.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (cap[p]) begin
        f_addr_q[p][wp_q[p]] <= addr[p];
        f_type_q[p][wp_q[p]] <=
          (cmd[p] == CMD_WRB) ? TYPE_WR : TYPE_RD;
        f_seq_q[p][wp_q[p]]  <= seq_q[p];
      end
    end
  end

  assign mbus_ack0_o    = ack_q[0];
  assign mbus_ack1_o    = ack_q[1];
  assign mbus_ack2_o    = ack_q[2];
  assign mbus_ack3_o    = ack_q[3];
  assign broad_valid_o  = valid_q;
  assign broad_addr_o   = oaddr_q;
  assign broad_type_o   = otype_q;
  assign broad_cpu_id_o = ocpu_q;
  assign broad_id_o     = oid_q;

`ifdef MESI_BREQ_STAT_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (valid_q && broad_ready_i && stat_q != 16'hFFFF)
      stat_d = stat_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign breq_stat_o  = stat_q;
  assign breq_stall_o = bcast & full;
`endif

endmodule

// File: tb/tb_mesi_isc_breq_arb.sv
// Bench for mesi_isc_breq_arb: queue-level reference model plus directed scenarios.
// Honours MESI_BREQ_STAT_EN when defined.
module tb_mesi_isc_breq_arb;

  localparam int FSIZE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic [2:0]  cmd  [4];
  logic [31:0] addr [4];
  logic        ack0, ack1, ack2, ack3;
  logic [3:0]  ack;
  logic        valid;
  logic [31:0] b_addr;
  logic [1:0]  b_type;
  logic [1:0]  b_cpu;
  logic [4:0]  b_id;
`ifdef MESI_BREQ_STAT_EN
  logic [15:0] stat;
  logic [3:0]  stall;
`endif

  assign ack = {ack3, ack2, ack1, ack0};

  always #5 clk = ~clk;

  mesi_isc_breq_arb dut (
    .clk            (clk),
    .rst            (rst),
    .mbus_cmd3_i    (cmd[3]),
    .mbus_cmd2_i    (cmd[2]),
    .mbus_cmd1_i    (cmd[1]),
    .mbus_cmd0_i    (cmd[0]),
    .mbus_addr3_i   (addr[3]),
    .mbus_addr2_i   (addr[2]),
    .mbus_addr1_i   (addr[1]),
    .mbus_addr0_i   (addr[0]),
    .mbus_ack3_o    (ack3),
    .mbus_ack2_o    (ack2),
    .mbus_ack1_o    (ack1),
    .mbus_ack0_o    (ack0),
    .broad_valid_o  (valid),
    .broad_ready_i  (ready),
    .broad_addr_o   (b_addr),
    .broad_type_o   (b_type),
    .broad_cpu_id_o (b_cpu),
    .broad_id_o     (b_id)
`ifdef MESI_BREQ_STAT_EN
    ,
    .breq_stat_o    (stat),
    .breq_stall_o   (stall)
`endif
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference model: each port is a bounded queue of pending requests.
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  typ;
    logic [4:0]  id;
  } ent_t;

  ent_t       mq [4][$];
  logic [3:0] m_ack = '0;
  logic [2:0] m_seq [4];
  logic       m_valid = 1'b0;
  ent_t       m_out;
  int         m_last = 3;
  int         m_stat = 0;

  function automatic bit is_bc(input logic [2:0] c);
    return (c == 3'd3) || (c == 3'd4);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 4; p++) begin
        mq[p].delete();
        m_seq[p] = 3'd0;
      end
      m_ack   = '0;
      m_valid = 1'b0;
      m_out   = '0;
      m_last  = 3;
      m_stat  = 0;
    end else begin
      bit   c [4];
      int   g;
      ent_t e;
      if (m_valid && ready && m_stat < 65535)
        m_stat++;
      for (int p = 0; p < 4; p++)
        c[p] = is_bc(cmd[p]) && !m_ack[p] &&
               (mq[p].size() < FSIZE);
      if (!m_valid || ready) begin
        g = -1;
        for (int k = 1; k <= 4; k++)
          if (g < 0 && mq[(m_last + k) % 4].size() > 0)
            g = (m_last + k) % 4;
        if (g >= 0) begin
          m_out   = mq[g].pop_front();
          m_valid = 1'b1;
          m_last  = g;
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (c[p]) begin
          e.addr = addr[p];
          e.typ  = (cmd[p] == 3'd3) ? 2'd1 : 2'd2;
          e.id   = {2'(p), m_seq[p]};
          mq[p].push_back(e);
          m_seq[p] = m_seq[p] + 3'd1;
        end
        m_ack[p] = c[p];
      end
    end
  end

  always @(negedge clk) begin
    chk("ack", 64'(ack), 64'(m_ack));
    chk("valid", 64'(valid), 64'(m_valid));
    if (m_valid) begin
      chk("addr", 64'(b_addr), 64'(m_out.addr));
      chk("type", 64'(b_type), 64'(m_out.typ));
      chk("cpu_id", 64'(b_cpu), 64'(m_out.id[4:3]));
      chk("id", 64'(b_id), 64'(m_out.id));
    end
`ifdef MESI_BREQ_STAT_EN
    begin
      logic [3:0] es;
      for (int p = 0; p < 4; p++)
        es[p] = is_bc(cmd[p]) && (mq[p].size() == FSIZE);
      chk("stat", 64'(stat), 64'(m_stat));
      chk("stall", 64'(stall), 64'(es));
    end
`endif
  end

  logic [4:0] hs [$];

  always @(negedge clk)
    if (!rst && valid && ready)
      hs.push_back(b_id);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int p = 0; p < 4; p++) begin
      cmd[p]  = 3'd0;
      addr[p] = '0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    logic [2:0] codes [6];
    codes[0] = 3'd1;
    codes[1] = 3'd2;
    codes[2] = 3'd7;
    codes[3] = 3'd5;
    codes[4] = 3'd6;
    codes[5] = 3'd0;

    for (int p = 0; p < 4; p++) begin
      cmd[p]  = 3'd0;
      addr[p] = '0;
    end
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_addr", 64'(b_addr), 64'd0);
    chk("rst_id", 64'(b_id), 64'd0);

    // Single write broadcast from port 1
    ready   = 1'b1;
    cmd[1]  = 3'd3;
    addr[1] = 32'h0000_1000;
    step();
    chk("t1_ack", 64'(ack), 64'b0010);
    step();
    cmd[1] = 3'd0;
    chk("t1_valid", 64'(valid), 64'd1);
    chk("t1_addr", 64'(b_addr), 64'h1000);
    chk("t1_type", 64'(b_type), 64'd1);
    chk("t1_cpu", 64'(b_cpu), 64'd1);
    chk("t1_id", 64'(b_id), 64'b01_000);
    step();
    chk("t1_idle", 64'(valid), 64'd0);

    // All four ports at once
    do_reset();
    ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      cmd[p]  = 3'd4;
      addr[p] = 32'h100 * (p + 1);
    end
    step();
    chk("t2_ack", 64'(ack), 64'hF);
    step();
    for (int p = 0; p < 4; p++) cmd[p] = 3'd0;
    for (int k = 0; k < 4; k++) begin
      chk("t2_cpu", 64'(b_cpu), 64'(k));
      chk("t2_id", 64'(b_id), 64'(k * 8));
      chk("t2_type", 64'(b_type), 64'd2);
      step();
    end
    chk("t2_idle", 64'(valid), 64'd0);

    // Backpressure: output held by port 0, port 2 fills FIFO
    do_reset();
    ready   = 1'b0;
    cmd[0]  = 3'd3;
    addr[0] = 32'hA0;
    step();
    step();
    cmd[0] = 3'd0;
    chk("t3_hold_valid", 64'(valid), 64'd1);
    chk("t3_hold_cpu", 64'(b_cpu), 64'd0);
    cmd[2]  = 3'd4;
    addr[2] = 32'h20;
    step();
    chk("t3_ack_a", 64'(ack2), 64'd1);
    step();
    addr[2] = 32'h24;
    step();
    chk("t3_ack_b", 64'(ack2), 64'd1);
    step();
    addr[2] = 32'h28;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_ack_held", 64'(ack2), 64'd0);
      chk("t3_out_stable", 64'(b_addr), 64'hA0);
`ifdef MESI_BREQ_STAT_EN
      chk("t3_stall", 64'(stall), 64'b0100);
`endif
    end
    hs.delete();
    ready = 1'b1;
    got   = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      step();
      got = ack2;
    end
    chk("t3_ack_c", 64'(got), 64'd1);
    step();
    cmd[2] = 3'd0;
    for (int i = 0; i < 4; i++) step();
    chk("t3_count", 64'(hs.size()), 64'd4);
    if (hs.size() == 4) begin
      chk("t3_id0", 64'(hs[0]), 64'b00_000);
      chk("t3_id1", 64'(hs[1]), 64'b10_000);
      chk("t3_id2", 64'(hs[2]), 64'b10_001);
      chk("t3_id3", 64'(hs[3]), 64'b10_010);
    end

    // Sequence wrap on port 0
    do_reset();
    ready = 1'b1;
    hs.delete();
    for (int i = 0; i < 9; i++) begin
      cmd[0]  = 3'd3;
      addr[0] = 32'h400 + 32'(4 * i);
      got     = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
        step();
        got = ack0;
      end
      chk("t4_ack", 64'(got), 64'd1);
      step();
      cmd[0] = 3'd0;
    end
    for (int i = 0; i < 4; i++) step();
    chk("t4_count", 64'(hs.size()), 64'd9);
    if (hs.size() == 9) begin
      chk("t4_id7", 64'(hs[7]), 64'b00_111);
      chk("t4_id8", 64'(hs[8]), 64'b00_000);
    end
`ifdef MESI_BREQ_STAT_EN
    chk("t4_stat", 64'(stat), 64'd9);
`endif

    // Non-broadcast commands on port 3
    do_reset();
    ready   = 1'b1;
    addr[3] = 32'h300;
    for (int i = 0; i < 6; i++) begin
      cmd[3] = codes[i];
      step();
      chk("t5_ack", 64'(ack3), 64'd0);
      step();
      chk("t5_valid", 64'(valid), 64'd0);
    end

    // Reset while a request is held
    do_reset();
    ready   = 1'b0;
    cmd[1]  = 3'd3;
    addr[1] = 32'h600;
    step();
    step();
    cmd[1] = 3'd0;
    chk("t6_pre_valid", 64'(valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(valid), 64'd0);
    chk("t6_addr", 64'(b_addr), 64'd0);
    chk("t6_type", 64'(b_type), 64'd0);
    chk("t6_cpu", 64'(b_cpu), 64'd0);
    chk("t6_id", 64'(b_id), 64'd0);
    step();
    rst   = 1'b0;
    ready = 1'b1;
    hs.delete();
    cmd[0]  = 3'd3;
    addr[0] = 32'h700;
    cmd[3]  = 3'd4;
    addr[3] = 32'h7C0;
    step();
    chk("t6_ack", 64'(ack), 64'b1001);
    step();
    cmd[0] = 3'd0;
    cmd[3] = 3'd0;
    chk("t6_first_cpu", 64'(b_cpu), 64'd0);
    chk("t6_first_id", 64'(b_id), 64'b00_000);
    step();
    chk("t6_second_cpu", 64'(b_cpu), 64'd3);
    chk("t6_second_id", 64'(b_id), 64'b11_000);
    step();
    chk("t6_count", 64'(hs.size()), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end

endmodule
